// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-port scheduler.
package fifo_pkg;

    // Width of the running pop counter; wraps silently at the top.
    localparam int POP_CNT_W = 16;

    // Largest supported consumer count and the index width that covers it.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    // Burst counter width; enough for BURST_MAX up to 15.
    localparam int BCNT_W    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // One-hot decode of a consumer index at the maximum width; callers
    // narrow the result to their own consumer count.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// Combinational round-robin picker. The search starts one above the most
// recent winner and wraps modulo N_REQ, so the previous winner is always
// considered last.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic found;
    int   cand;

    // Scan upward from last+1; the first requester seen wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last) + i) % N_REQ;
            if (!found && req[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-port scheduler: shares one FIFO read port between N_REQ consumers,
// granting round-robin bursts of up to BURST_MAX pops and steering each
// returned word to the consumer that popped it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; ren=0, gnt=0; arbitrate when req!=0 and FIFO not empty
//   BURST | owner holds the port; pop whenever owner requests, is ready and
//         | FIFO not empty; leave after the last pop, on req drop or empty
module fifo_rd_sched
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                 rclk,
    input  logic                 rrstn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     rdy,
    input  logic                 empty,
    input  logic [D_WIDTH-1:0]   rdata,
    output logic                 ren,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     dvalid,
    output logic [D_WIDTH-1:0]   dout,
    output logic [POP_CNT_W-1:0] pop_cnt
);

    localparam int                IDX_W     = $clog2(N_REQ);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N_REQ - 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       last_q;
    logic [BCNT_W-1:0]      bcnt_q;
    logic [BCNT_W-1:0]      bcnt_d;
    logic [N_REQ-1:0]       gnt_q;
    logic [POP_CNT_W-1:0]   pop_cnt_q;
    logic [POP_CNT_W-1:0]   pop_cnt_d;
    logic                   ren_dly_q;
    logic [IDX_W-1:0]       own_dly_q;

    logic                   arb_any;
    logic [IDX_W-1:0]       arb_winner;
    logic [N_REQ-1:0]       win_oh;
    logic                   burst_end;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req),
        .last   (last_q),
        .any    (arb_any),
        .winner (arb_winner)
    );

    // Pop strobe is combinational so a consumer dropping rdy or the FIFO
    // going empty stops the pop in the very same cycle.
    always_comb begin
        ren = (state_q == BURST) && req[owner_q] && rdy[owner_q] && !empty;
    end

    // Next values for the counters and the burst release decision.
    always_comb begin
        bcnt_d    = bcnt_q + BCNT_W'(1);
        pop_cnt_d = pop_cnt_q + POP_CNT_W'(1);
        win_oh    = N_REQ'(onehot(MAX_IDX_W'(arb_winner)));
        burst_end = (ren && (bcnt_q == BCNT_LAST)) || !req[owner_q] || empty;
    end

    // Scheduler FSM with registered grant, plus the return-path pipeline.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= LAST_RST;
            bcnt_q    <= '0;
            gnt_q     <= '0;
            pop_cnt_q <= '0;
            ren_dly_q <= 1'b0;
            own_dly_q <= '0;
        end else begin
            ren_dly_q <= ren;
            own_dly_q <= owner_q;
            if (ren) begin
                pop_cnt_q <= pop_cnt_d;
            end
            case (state_q)
                IDLE: begin
                    if (arb_any && !empty) begin
                        owner_q <= arb_winner;
                        last_q  <= arb_winner;
                        bcnt_q  <= '0;
                        gnt_q   <= win_oh;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (ren) begin
                        bcnt_q <= bcnt_d;
                    end
                    // Always fall back through IDLE so the next winner is
                    // chosen with this owner at lowest priority.
                    if (burst_end) begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Words arrive one cycle after the pop and belong to whoever popped them,
    // even if the grant has already moved on.
    always_comb begin
        dvalid = ren_dly_q ? N_REQ'(onehot(MAX_IDX_W'(own_dly_q))) : '0;
    end

    assign gnt     = gnt_q;
    assign dout    = rdata;
    assign pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
module tb_fifo_rd_sched;

    logic        rclk  = 1'b0;
    logic        rrstn = 1'b0;
    logic [3:0]  req   = 4'b0000;
    logic [3:0]  rdy   = 4'b1111;
    logic        empty;
    logic [7:0]  rdata = 8'h00;
    logic        ren;
    logic [3:0]  gnt;
    logic [3:0]  dvalid;
    logic [7:0]  dout;
    logic [15:0] pop_cnt;

    int total = 0;
    int bad   = 0;

    // FIFO read-side model: words written by the tasks, popped on ren.
    logic [7:0] mem [0:1023];
    int wptr = 0;
    int rptr = 0;

    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];
    int  dv_cnt[4] = '{default: 0};

    fifo_rd_sched #(
        .N_REQ     (4),
        .D_WIDTH   (8),
        .BURST_MAX (4)
    ) dut (
        .rclk    (rclk),
        .rrstn   (rrstn),
        .req     (req),
        .rdy     (rdy),
        .empty   (empty),
        .rdata   (rdata),
        .ren     (ren),
        .gnt     (gnt),
        .dvalid  (dvalid),
        .dout    (dout),
        .pop_cnt (pop_cnt)
    );

    always #5 rclk = ~rclk;

    assign empty = (wptr == rptr);

    always @(posedge rclk) begin
        if (ren) begin
            rdata <= mem[rptr];
            rptr  <= rptr + 1;
        end
    end

    // Scoreboard: expected word/owner pushed on each pop, checked next cycle.
    always @(negedge rclk) begin
        sb_t e;
        if (!rrstn) begin
            sb.delete();
        end else begin
            total++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (dvalid !== e.oh || dout !== e.data) begin
                    bad++;
                    $display("FAIL sb_return: dvalid=%b dout=%h expected dvalid=%b dout=%h",
                             dvalid, dout, e.oh, e.data);
                end
            end else if (dvalid !== 4'b0000) begin
                bad++;
                $display("FAIL sb_spurious: dvalid=%b expected 0000", dvalid);
            end
            for (int k = 0; k < 4; k++) if (dvalid[k]) dv_cnt[k]++;
            if (ren) sb.push_back('{oh: gnt, data: mem[rptr]});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr] = 8'($urandom_range(0, 255));
            wptr++;
        end
    endtask

    task automatic apply_reset();
        rrstn = 1'b0;
        req   = 4'b0000;
        rdy   = 4'b1111;
        #1;
        wptr  = rptr;
        tick();
        tick();
        rrstn = 1'b1;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (gnt !== 4'b0000) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rrstn = 1'b0;
        #2;
        total++; if (ren !== 1'b0)        begin bad++; $display("FAIL rst_ren: got %b want 0", ren); end
        total++; if (gnt !== 4'b0000)     begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        total++; if (dvalid !== 4'b0000)  begin bad++; $display("FAIL rst_dvalid: got %b want 0000", dvalid); end
        total++; if (pop_cnt !== 16'h0)   begin bad++; $display("FAIL rst_pop_cnt: got %h want 0000", pop_cnt); end
    endtask

    task automatic test_single();
        logic [9:0] pat;
        int dv0;
        apply_reset();
        push_words(6);
        dv0 = dv_cnt[0];
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) #1; else tick();
            pat[9-i] = ren;
        end
        total++; if (pat !== 10'b0111101100) begin bad++; $display("FAIL single_ren_pattern: got %b want 0111101100", pat); end
        total++; if (pop_cnt !== 16'd6)      begin bad++; $display("FAIL single_pop_cnt: got %0d want 6", pop_cnt); end
        total++; if (dv_cnt[0] - dv0 != 6)   begin bad++; $display("FAIL single_dvalid_cnt: got %0d want 6", dv_cnt[0] - dv0); end
        total++; if (gnt !== 4'b0000)        begin bad++; $display("FAIL single_idle_gnt: got %b want 0000", gnt); end
        req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] g_seq[8];
        int         g_pops[8];
        int         ng;
        logic [3:0] prev;
        logic [3:0] exp_g;
        ng   = 0;
        prev = 4'b0000;
        apply_reset();
        push_words(40);
        req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gnt != 4'b0000 && gnt != prev && ng < 8) begin
                g_seq[ng]  = gnt;
                g_pops[ng] = 0;
                ng++;
            end
            if (ren && ng > 0) g_pops[ng-1]++;
            prev = gnt;
        end
        total++; if (ng < 5) begin bad++; $display("FAIL rr_grant_count: got %0d want >=5", ng); end
        for (int k = 0; k < 5; k++) begin
            if (k < ng) begin
                exp_g = 4'b0001 << (k % 4);
                total++; if (g_seq[k] !== exp_g) begin bad++; $display("FAIL rr_order[%0d]: got %b want %b", k, g_seq[k], exp_g); end
                total++; if (g_pops[k] != 4)     begin bad++; $display("FAIL rr_pops[%0d]: got %0d want 4", k, g_pops[k]); end
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_empty_mid();
        int         pops;
        logic [3:0] first_g;
        logic [3:0] g;
        pops    = 0;
        first_g = 4'b0000;
        apply_reset();
        push_words(2);
        req = 4'b1100;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (first_g == 4'b0000 && gnt != 4'b0000) first_g = gnt;
            if (ren) pops++;
            total++; if ((ren & empty) !== 1'b0) begin bad++; $display("FAIL empty_no_pop: ren=%b empty=%b want ren=0", ren, empty); end
        end
        total++; if (first_g !== 4'b0100) begin bad++; $display("FAIL empty_owner: got %b want 0100", first_g); end
        total++; if (pops != 2)           begin bad++; $display("FAIL empty_pops: got %0d want 2", pops); end
        total++; if (gnt !== 4'b0000)     begin bad++; $display("FAIL empty_idle: got %b want 0000", gnt); end
        push_words(4);
        wait_gnt(g);
        total++; if (g !== 4'b1000) begin bad++; $display("FAIL refill_next: got %b want 1000", g); end
        req = 4'b0100;
        g = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (gnt != 4'b0000 && gnt != 4'b1000) begin
                g = gnt;
                break;
            end
        end
        total++; if (g !== 4'b0100) begin bad++; $display("FAIL refill_same: got %b want 0100", g); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] g;
        int         pops;
        apply_reset();
        push_words(10);
        req = 4'b0010;
        wait_gnt(g);
        total++; if (g !== 4'b0010) begin bad++; $display("FAIL bp_gnt: got %b want 0010", g); end
        total++; if (ren !== 1'b1)  begin bad++; $display("FAIL bp_first_ren: got %b want 1", ren); end
        pops = ren ? 1 : 0;
        tick();
        for (int s = 0; s < 3; s++) begin
            rdy = 4'b1101;
            #1;
            total++; if (ren !== 1'b0)    begin bad++; $display("FAIL bp_stall_ren[%0d]: got %b want 0", s, ren); end
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL bp_stall_gnt[%0d]: got %b want 0010", s, gnt); end
            tick();
        end
        rdy = 4'b1111;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (gnt == 4'b0000) break;
            if (ren) pops++;
            tick();
        end
        total++; if (pops != 4)        begin bad++; $display("FAIL bp_burst_pops: got %0d want 4", pops); end
        total++; if (pop_cnt !== 16'd4) begin bad++; $display("FAIL bp_pop_cnt: got %0d want 4", pop_cnt); end
        total++; if (gnt !== 4'b0000)  begin bad++; $display("FAIL bp_release: got %b want 0000", gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_req_drop();
        logic [3:0] g;
        apply_reset();
        push_words(8);
        req = 4'b0001;
        wait_gnt(g);
        total++; if (ren !== 1'b1) begin bad++; $display("FAIL drop_first_ren: got %b want 1", ren); end
        tick();
        req = 4'b0000;
        #1;
        total++; if (ren !== 1'b0)       begin bad++; $display("FAIL drop_ren: got %b want 0", ren); end
        total++; if (dvalid !== 4'b0001) begin bad++; $display("FAIL drop_inflight: got %b want 0001", dvalid); end
        tick();
        total++; if (gnt !== 4'b0000)    begin bad++; $display("FAIL drop_idle: got %b want 0000", gnt); end
        total++; if (pop_cnt !== 16'd1)  begin bad++; $display("FAIL drop_pop_cnt: got %0d want 1", pop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        apply_reset();
        push_words(10);
        req = 4'b1000;
        wait_gnt(g);
        total++; if (g !== 4'b1000) begin bad++; $display("FAIL rm_gnt: got %b want 1000", g); end
        tick();
        rrstn = 1'b0;
        #1;
        total++; if (ren !== 1'b0)       begin bad++; $display("FAIL rm_ren: got %b want 0", ren); end
        total++; if (gnt !== 4'b0000)    begin bad++; $display("FAIL rm_gnt_clr: got %b want 0000", gnt); end
        total++; if (dvalid !== 4'b0000) begin bad++; $display("FAIL rm_dvalid: got %b want 0000", dvalid); end
        total++; if (pop_cnt !== 16'h0)  begin bad++; $display("FAIL rm_pop_cnt: got %0d want 0", pop_cnt); end
        tick();
        tick();
        req   = 4'b1111;
        rrstn = 1'b1;
        wait_gnt(g);
        total++; if (g !== 4'b0001) begin bad++; $display("FAIL rm_first_gnt: got %b want 0001", g); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_empty_mid();
        test_backpressure();
        test_req_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
